// File: rtl/soft_uart_pkg.sv
// Shared encodings for soft_uart: FSM states, frame parity codes and the
// default bit period (11.0592 MHz clock, 115200 baud).
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 96;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Line level of the parity bit for a byte under the given parity code.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/soft_uart_if.sv
// Host-side bus of soft_uart: byte in/out, active-low strobes, status flags.
interface soft_uart_if;
  // Strobes: wrn/rdn are active low; a write or read takes effect on the clock
  // that first samples the 1->0 transition. There is no ready return: the host
  // polls tbre before writing and data_ready before reading, and a write made
  // while tbre=0 is silently dropped.
  logic [7:0] data_in;
  logic       wrn;
  logic       rdn;
  logic [7:0] data_out;
  logic       tbre;
  logic       tsre;
  logic       data_ready;
  logic       parity_error;
  logic       framing_error;

  modport master (
    output data_in, wrn, rdn,
    input  data_out, tbre, tsre, data_ready, parity_error, framing_error
  );

  modport slave (
    input  data_in, wrn, rdn,
    output data_out, tbre, tsre, data_ready, parity_error, framing_error
  );
endinterface

// File: rtl/soft_uart_rx.sv
// Receive path: rxd synchronizer, start-bit qualification, mid-bit sampling,
// and the received byte with its error flags.
module soft_uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = PARITY_NONE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       read_ev,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       parity_error,
  output logic       framing_error,
  output rx_state_t  state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_s1;
  logic          rx_s2;
  logic          rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_par;
  logic          bit_end;

  assign bit_end = (rx_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_prev       <= 1'b1;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_par        <= 1'b0;
      data_out      <= '0;
      data_ready    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      state         <= RX_IDLE;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;

      // A read clears the flags; a frame completing in the same cycle
      // assigns them again further down and therefore wins.
      if (read_ev) begin
        data_ready    <= 1'b0;
        parity_error  <= 1'b0;
        framing_error <= 1'b0;
      end

      case (state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_s2) state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            // A line that is high again at mid start bit was only a glitch.
            state  <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_end) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 4'd7) begin
              state <= (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit <= rx_bit + 4'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (bit_end) begin
            rx_cnt <= '0;
            rx_par <= rx_s2;
            state  <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_end) begin
            rx_cnt        <= '0;
            data_out      <= rx_shift;
            data_ready    <= 1'b1;
            framing_error <= ~rx_s2;
            parity_error  <= (PARITY != PARITY_NONE) ?
                             (rx_par != parity_bit(rx_shift, PARITY)) : 1'b0;
            state         <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/soft_uart.sv
// soft_uart top: host strobe edge detection, transmit holding register and
// transmit FSM; the receive path lives in soft_uart_rx.
module soft_uart
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = PARITY_NONE
) (
  input  logic       clk,
  input  logic       rst,
  soft_uart_if.slave bus,
  input  logic       rxd,
  output logic       txd,
  output tx_state_t  tx_state,
  output rx_state_t  rx_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic          wrn_q;
  logic          rdn_q;
  logic          write_ev;
  logic          read_ev;
  logic [7:0]    thr;
  logic          tbre_r;
  logic          tsre_r;
  logic          txd_r;
  logic [7:0]    tx_shift;
  logic          tx_par;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  tx_state_t     tx_st;
  logic          bit_end;
  logic          start_frame;

  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          rx_perr;
  logic          rx_ferr;

  assign write_ev = wrn_q & ~bus.wrn;
  assign read_ev  = rdn_q & ~bus.rdn;
  assign bit_end  = (tx_cnt == CNT_LAST);
  // A pending byte starts from IDLE, or straight out of the last stop-bit
  // cycle so consecutive frames leave no idle gap on the line.
  assign start_frame = !tbre_r &&
                       ((tx_st == TX_IDLE) || (tx_st == TX_STOP && bit_end));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrn_q    <= 1'b1;
      rdn_q    <= 1'b1;
      thr      <= '0;
      tbre_r   <= 1'b1;
      tsre_r   <= 1'b1;
      txd_r    <= 1'b1;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_st    <= TX_IDLE;
    end else begin
      wrn_q <= bus.wrn;
      rdn_q <= bus.rdn;

      if (write_ev && tbre_r) begin
        thr    <= bus.data_in;
        tbre_r <= 1'b0;
      end

      if (start_frame) begin
        tx_shift <= thr;
        tx_par   <= parity_bit(thr, PARITY);
        tbre_r   <= 1'b1;
        tsre_r   <= 1'b0;
        txd_r    <= 1'b0;
        tx_cnt   <= '0;
        tx_st    <= TX_START;
      end else begin
        if (tx_st != TX_IDLE) tx_cnt <= bit_end ? '0 : tx_cnt + 1'b1;
        case (tx_st)
          TX_START: begin
            if (bit_end) begin
              txd_r    <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= '0;
              tx_st    <= TX_DATA;
            end
          end
          TX_DATA: begin
            if (bit_end) begin
              if (tx_bit == 4'd7) begin
                if (PARITY != PARITY_NONE) begin
                  txd_r <= tx_par;
                  tx_st <= TX_PARITY;
                end else begin
                  txd_r <= 1'b1;
                  tx_st <= TX_STOP;
                end
              end else begin
                txd_r    <= tx_shift[0];
                tx_shift <= tx_shift >> 1;
                tx_bit   <= tx_bit + 4'd1;
              end
            end
          end
          TX_PARITY: begin
            if (bit_end) begin
              txd_r <= 1'b1;
              tx_st <= TX_STOP;
            end
          end
          TX_STOP: begin
            if (bit_end) begin
              tsre_r <= 1'b1;
              tx_st  <= TX_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  soft_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .PARITY       (PARITY)
  ) u_rx (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .read_ev       (read_ev),
    .data_out      (rx_data),
    .data_ready    (rx_ready),
    .parity_error  (rx_perr),
    .framing_error (rx_ferr),
    .state         (rx_state)
  );

  assign txd               = txd_r;
  assign tx_state          = tx_st;
  assign bus.tbre          = tbre_r;
  assign bus.tsre          = tsre_r;
  assign bus.data_out      = rx_data;
  assign bus.data_ready    = rx_ready;
  assign bus.parity_error  = rx_perr;
  assign bus.framing_error = rx_ferr;

endmodule

// File: tb/tb_soft_uart.sv
// Directed bench for soft_uart: dut0 frames without parity, dut1 with even
// parity, both at 96 clocks per bit.
module tb_soft_uart;
  import uart_pkg::*;

  localparam int N = 96;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  logic      rxd0 = 1'b1;
  logic      rxd1 = 1'b1;
  logic      txd0;
  logic      txd1;
  tx_state_t tx_st0;
  tx_state_t tx_st1;
  rx_state_t rx_st0;
  rx_state_t rx_st1;
  int        checks = 0;
  int        failures = 0;

  soft_uart_if bus0();
  soft_uart_if bus1();

  soft_uart #(.CLKS_PER_BIT(N), .PARITY(PARITY_NONE)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .rxd(rxd0), .txd(txd0),
    .tx_state(tx_st0), .rx_state(rx_st0)
  );

  soft_uart #(.CLKS_PER_BIT(N), .PARITY(PARITY_EVEN)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .rxd(rxd1), .txd(txd1),
    .tx_state(tx_st1), .rx_state(rx_st1)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  function automatic logic get_txd(input int u);
    return (u == 0) ? txd0 : txd1;
  endfunction

  function automatic logic get_tbre(input int u);
    return (u == 0) ? bus0.tbre : bus1.tbre;
  endfunction

  function automatic logic get_tsre(input int u);
    return (u == 0) ? bus0.tsre : bus1.tsre;
  endfunction

  task automatic set_rxd(input int u, input logic v);
    if (u == 0) rxd0 = v; else rxd1 = v;
  endtask

  task automatic write_byte(input int u, input logic [7:0] b);
    @(negedge clk);
    if (u == 0) begin bus0.data_in = b; bus0.wrn = 1'b0; end
    else        begin bus1.data_in = b; bus1.wrn = 1'b0; end
    @(negedge clk);
    if (u == 0) bus0.wrn = 1'b1; else bus1.wrn = 1'b1;
  endtask

  task automatic read_pulse(input int u);
    @(negedge clk);
    if (u == 0) bus0.rdn = 1'b0; else bus1.rdn = 1'b0;
    @(negedge clk);
    if (u == 0) bus0.rdn = 1'b1; else bus1.rdn = 1'b1;
  endtask

  // Drives one serial frame on rxd (start, data LSB first, optional parity, stop).
  task automatic send_rx(input int u, input logic [7:0] b, input bit has_par,
                         input logic par, input logic stop);
    logic [10:0] bits;
    int nb;
    nb   = has_par ? 11 : 10;
    bits = has_par ? {stop, par, b, 1'b0} : {1'b0, stop, b, 1'b0};
    @(negedge clk);
    for (int k = 0; k < nb; k++) begin
      set_rxd(u, bits[k]);
      repeat (N) @(negedge clk);
    end
    set_rxd(u, 1'b1);
  endtask

  // Records txd at the first and last cycle of every bit of one frame,
  // starting at the first negedge that shows the start bit.
  task automatic capture_tx(input int u, input int nb,
                            output logic [10:0] lvl_s, output logic [10:0] lvl_e,
                            output bit found, output logic tbre0, output logic tsre0,
                            output logic tsre_last, output logic txd_after,
                            output logic tsre_after);
    int waited;
    waited = 0;
    found  = 1'b0;
    lvl_s  = 'x;
    lvl_e  = 'x;
    tbre0 = 1'bx; tsre0 = 1'bx; tsre_last = 1'bx; txd_after = 1'bx; tsre_after = 1'bx;
    while (get_txd(u) !== 1'b0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (get_txd(u) === 1'b0) begin
      found = 1'b1;
      lvl_s = '0;
      lvl_e = '0;
      tbre0 = get_tbre(u);
      tsre0 = get_tsre(u);
      for (int t = 0; t < nb * N; t++) begin
        if (t % N == 0)     lvl_s[t / N] = get_txd(u);
        if (t % N == N - 1) lvl_e[t / N] = get_txd(u);
        if (t == nb * N - 1) tsre_last = get_tsre(u);
        @(negedge clk);
      end
      txd_after  = get_txd(u);
      tsre_after = get_tsre(u);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (txd0 !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b want 1", txd0); end
    checks++; if (bus0.tbre !== 1'b1) begin failures++; $display("FAIL reset_tbre: got %b want 1", bus0.tbre); end
    checks++; if (bus0.tsre !== 1'b1) begin failures++; $display("FAIL reset_tsre: got %b want 1", bus0.tsre); end
    checks++; if (bus0.data_ready !== 1'b0) begin failures++; $display("FAIL reset_data_ready: got %b want 0", bus0.data_ready); end
    checks++; if (bus0.parity_error !== 1'b0 || bus0.framing_error !== 1'b0) begin
      failures++; $display("FAIL reset_err_flags: got pe=%b fe=%b want 0/0", bus0.parity_error, bus0.framing_error); end
    checks++; if (bus0.data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out: got %h want 00", bus0.data_out); end
    checks++; if (tx_st0 !== TX_IDLE || rx_st0 !== RX_IDLE) begin
      failures++; $display("FAIL reset_states: got tx=%0d rx=%0d want 0/0", tx_st0, rx_st0); end
    checks++; if (txd1 !== 1'b1 || bus1.tbre !== 1'b1) begin
      failures++; $display("FAIL reset_dut1: got txd=%b tbre=%b want 1/1", txd1, bus1.tbre); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tx_single();
    logic [10:0] ls, le;
    bit found;
    logic tb0, ts0, tsl, txa, tsa;
    write_byte(0, 8'h55);
    checks++; if (bus0.tbre !== 1'b0) begin failures++; $display("FAIL tx55_tbre_low: got %b want 0", bus0.tbre); end
    capture_tx(0, 10, ls, le, found, tb0, ts0, tsl, txa, tsa);
    checks++; if (!found) begin failures++; $display("FAIL tx55_start: got no start bit want start within 300 cycles"); end
    checks++; if (ls !== 11'h2AA || le !== 11'h2AA) begin
      failures++; $display("FAIL tx55_bits: got first=%h last=%h want 2aa", ls, le); end
    checks++; if (tb0 !== 1'b1) begin failures++; $display("FAIL tx55_tbre_back: got %b want 1", tb0); end
    checks++; if (ts0 !== 1'b0 || tsl !== 1'b0 || tsa !== 1'b1) begin
      failures++; $display("FAIL tx55_tsre_960: got first=%b last=%b after=%b want 0/0/1", ts0, tsl, tsa); end
    checks++; if (txa !== 1'b1) begin failures++; $display("FAIL tx55_idle: got %b want 1", txa); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] ls1, le1, ls2, le2;
    bit f1, f2;
    logic tb1, ts1, tsl1, txa1, tsa1, tb2, ts2, tsl2, txa2, tsa2;
    logic tbre_after_drop;
    tbre_after_drop = 1'bx;
    write_byte(0, 8'hA5);
    fork
      begin
        capture_tx(0, 10, ls1, le1, f1, tb1, ts1, tsl1, txa1, tsa1);
        capture_tx(0, 10, ls2, le2, f2, tb2, ts2, tsl2, txa2, tsa2);
      end
      begin
        for (int i = 0; i < 50 && bus0.tbre !== 1'b1; i++) @(negedge clk);
        write_byte(0, 8'h3C);
        write_byte(0, 8'hFF);
        tbre_after_drop = bus0.tbre;
      end
    join
    checks++; if (tbre_after_drop !== 1'b0) begin failures++; $display("FAIL b2b_tbre_full: got %b want 0", tbre_after_drop); end
    checks++; if (!f1 || ls1 !== 11'h34A || le1 !== 11'h34A) begin
      failures++; $display("FAIL b2b_frame_a5: got first=%h last=%h want 34a", ls1, le1); end
    checks++; if (txa1 !== 1'b0 || tsa1 !== 1'b0) begin
      failures++; $display("FAIL b2b_no_gap: got txd=%b tsre=%b want 0/0", txa1, tsa1); end
    checks++; if (!f2 || ls2 !== 11'h278 || le2 !== 11'h278) begin
      failures++; $display("FAIL b2b_frame_3c: got first=%h last=%h want 278", ls2, le2); end
    checks++; if (txa2 !== 1'b1 || tsa2 !== 1'b1 || bus0.tbre !== 1'b1) begin
      failures++; $display("FAIL b2b_drop: got txd=%b tsre=%b tbre=%b want 1/1/1", txa2, tsa2, bus0.tbre); end
  endtask

  task automatic test_rx_duplex();
    logic [10:0] ls, le;
    bit found;
    logic tb0, ts0, tsl, txa, tsa;
    write_byte(0, 8'h5A);
    fork
      capture_tx(0, 10, ls, le, found, tb0, ts0, tsl, txa, tsa);
      send_rx(0, 8'hC3, 1'b0, 1'b0, 1'b1);
    join
    repeat (4) @(negedge clk);
    checks++; if (!found || ls !== 11'h2B4 || le !== 11'h2B4) begin
      failures++; $display("FAIL duplex_tx_5a: got first=%h last=%h want 2b4", ls, le); end
    checks++; if (bus0.data_out !== 8'hC3) begin failures++; $display("FAIL rx_c3_data: got %h want c3", bus0.data_out); end
    checks++; if (bus0.data_ready !== 1'b1 || bus0.framing_error !== 1'b0 || bus0.parity_error !== 1'b0) begin
      failures++; $display("FAIL rx_c3_flags: got dr=%b fe=%b pe=%b want 1/0/0",
                           bus0.data_ready, bus0.framing_error, bus0.parity_error); end
    read_pulse(0);
    @(negedge clk);
    checks++; if (bus0.data_ready !== 1'b0 || bus0.data_out !== 8'hC3) begin
      failures++; $display("FAIL rx_c3_read: got dr=%b data=%h want 0/c3", bus0.data_ready, bus0.data_out); end
  endtask

  task automatic test_rx_errors();
    logic [10:0] ls, le;
    bit found;
    logic tb0, ts0, tsl, txa, tsa;
    send_rx(0, 8'h81, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (bus0.framing_error !== 1'b1 || bus0.data_ready !== 1'b1 || bus0.data_out !== 8'h81) begin
      failures++; $display("FAIL rx_framing: got fe=%b dr=%b data=%h want 1/1/81",
                           bus0.framing_error, bus0.data_ready, bus0.data_out); end
    read_pulse(0);
    @(negedge clk);
    checks++; if (bus0.framing_error !== 1'b0 || bus0.data_ready !== 1'b0) begin
      failures++; $display("FAIL rx_framing_clear: got fe=%b dr=%b want 0/0", bus0.framing_error, bus0.data_ready); end
    send_rx(1, 8'h07, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (bus1.parity_error !== 1'b0 || bus1.data_ready !== 1'b1 || bus1.data_out !== 8'h07) begin
      failures++; $display("FAIL rx_parity_good: got pe=%b dr=%b data=%h want 0/1/07",
                           bus1.parity_error, bus1.data_ready, bus1.data_out); end
    read_pulse(1);
    send_rx(1, 8'h07, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (bus1.parity_error !== 1'b1 || bus1.framing_error !== 1'b0 || bus1.data_ready !== 1'b1) begin
      failures++; $display("FAIL rx_parity_bad: got pe=%b fe=%b dr=%b want 1/0/1",
                           bus1.parity_error, bus1.framing_error, bus1.data_ready); end
    write_byte(1, 8'h07);
    capture_tx(1, 11, ls, le, found, tb0, ts0, tsl, txa, tsa);
    checks++; if (!found || ls !== 11'h60E || le !== 11'h60E || tsa !== 1'b1) begin
      failures++; $display("FAIL tx_even_parity: got first=%h last=%h tsre=%b want 60e/60e/1", ls, le, tsa); end
  endtask

  task automatic test_glitch_overrun();
    @(negedge clk);
    rxd0 = 1'b0;
    repeat (20) @(negedge clk);
    rxd0 = 1'b1;
    repeat (100) @(negedge clk);
    checks++; if (bus0.data_ready !== 1'b0 || rx_st0 !== RX_IDLE || bus0.data_out !== 8'h81) begin
      failures++; $display("FAIL rx_glitch: got dr=%b state=%0d data=%h want 0/0/81",
                           bus0.data_ready, rx_st0, bus0.data_out); end
    send_rx(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_rx(0, 8'h22, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (bus0.data_out !== 8'h22 || bus0.data_ready !== 1'b1) begin
      failures++; $display("FAIL rx_overrun: got data=%h dr=%b want 22/1", bus0.data_out, bus0.data_ready); end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] ls, le;
    bit found;
    logic tb0, ts0, tsl, txa, tsa;
    int waited;
    write_byte(0, 8'h00);
    waited = 0;
    while (txd0 !== 1'b0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    rxd0 = 1'b0;
    repeat (4 * N + N / 2) @(negedge clk);
    checks++; if (txd0 !== 1'b0 || tx_st0 !== TX_DATA || rx_st0 !== RX_DATA) begin
      failures++; $display("FAIL mid_frame_pre: got txd=%b tx=%0d rx=%0d want 0/2/2", txd0, tx_st0, rx_st0); end
    rst = 1'b0;
    #1;
    checks++; if (txd0 !== 1'b1 || bus0.tbre !== 1'b1 || bus0.tsre !== 1'b1) begin
      failures++; $display("FAIL mid_reset_tx: got txd=%b tbre=%b tsre=%b want 1/1/1", txd0, bus0.tbre, bus0.tsre); end
    checks++; if (bus0.data_ready !== 1'b0 || bus0.parity_error !== 1'b0 ||
                  bus0.framing_error !== 1'b0 || bus0.data_out !== 8'h00) begin
      failures++; $display("FAIL mid_reset_rx: got dr=%b pe=%b fe=%b data=%h want 0/0/0/00",
                           bus0.data_ready, bus0.parity_error, bus0.framing_error, bus0.data_out); end
    checks++; if (tx_st0 !== TX_IDLE || rx_st0 !== RX_IDLE) begin
      failures++; $display("FAIL mid_reset_states: got tx=%0d rx=%0d want 0/0", tx_st0, rx_st0); end
    rxd0 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    write_byte(0, 8'h96);
    capture_tx(0, 10, ls, le, found, tb0, ts0, tsl, txa, tsa);
    checks++; if (!found || ls !== 11'h32C || le !== 11'h32C || txa !== 1'b1 || tsa !== 1'b1) begin
      failures++; $display("FAIL post_reset_tx: got first=%h last=%h txd=%b tsre=%b want 32c/32c/1/1",
                           ls, le, txa, tsa); end
    checks++; if (bus0.data_ready !== 1'b0) begin
      failures++; $display("FAIL post_reset_rx_quiet: got dr=%b want 0", bus0.data_ready); end
  endtask

  initial begin
    bus0.data_in = 8'h00; bus0.wrn = 1'b1; bus0.rdn = 1'b1;
    bus1.data_in = 8'h00; bus1.wrn = 1'b1; bus1.rdn = 1'b1;
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx_duplex();
    test_rx_errors();
    test_glitch_overrun();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
